// File: rtl/tx_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter: sender states,
// frame tags and the queue entry width.
package tx_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_FREE = 2'd1,
    ST_SEND      = 2'd2,
    ST_WAIT_DONE = 2'd3
  } tx_state_t;

  localparam logic TAG_RF  = 1'b0;
  localparam logic TAG_ALU = 1'b1;

  // Entry = {tag, two data bytes}; RF frames leave the upper byte zero.
  function automatic int entry_width(input int data_width);
    return 2 * data_width + 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with two write ports so a pair of frames can be queued in
// one cycle. Full/empty are registered from the next-state occupancy.
module sync_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push0,
  input  logic [WIDTH-1:0]           push0_data,
  input  logic                       push1,
  input  logic [WIDTH-1:0]           push1_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, wr_ptr_next, rd_ptr_reg, rd_ptr_next;
  logic [AW-1:0]    wr_ptr1;
  logic [CW-1:0]    count_reg, count_next;
  logic             full_reg, empty_reg;
  logic             pop_ok;

  // The caller guarantees capacity for pushes; pops on an empty queue are ignored.
  assign pop_ok      = pop && !empty_reg;
  assign wr_ptr1     = wr_ptr_reg + AW'(push0);
  assign wr_ptr_next = wr_ptr_reg + AW'(push0) + AW'(push1);
  assign rd_ptr_next = rd_ptr_reg + AW'(pop_ok);
  assign count_next  = count_reg + CW'(push0) + CW'(push1) - CW'(pop_ok);

  always_ff @(posedge clk) begin
    if (push0) mem[wr_ptr_reg] <= push0_data;
    if (push1) mem[wr_ptr1]    <= push1_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      full_reg   <= 1'b0;
      empty_reg  <= 1'b1;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      full_reg   <= (count_next == CW'(DEPTH));
      empty_reg  <= (count_next == '0);
    end
  end

  assign head_data = mem[rd_ptr_reg];
  assign full      = full_reg;
  assign empty     = empty_reg;
  assign count     = count_reg;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Queues RF (1-byte) and ALU (2-byte) result frames and feeds them byte by
// byte into UART_TX via the Busy handshake, abandoning a frame on a lost ack.
module uart_tx_arbiter
  import tx_arb_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DATA_WIDTH-1:0]   RdData,
  input  logic                    RdData_Valid,
  input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
  input  logic                    OUT_VALID,
  input  logic                    Busy,
  output logic [DATA_WIDTH-1:0]   TX_P_DATA,
  output logic                    TX_D_VLD,
  output logic                    Fifo_Full,
  output logic                    Overflow,
  output logic                    Ack_Timeout
);

  localparam int EW = entry_width(DATA_WIDTH);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  logic [EW-1:0]  rf_entry, alu_entry;
  logic [EW-1:0]  push0_data, push1_data, fifo_head;
  logic           push0, push1, fifo_pop;
  logic           fifo_full, fifo_empty;
  logic [CW-1:0]  fifo_count, free_slots;
  logic           drop;

  tx_state_t               state_reg, state_next;
  logic [EW-1:0]           frame_reg, frame_next;
  logic                    byte_idx_reg, byte_idx_next;
  logic [DATA_WIDTH-1:0]   tx_data_reg, tx_data_next;
  logic                    tx_vld_reg, tx_vld_next;
  logic [TW-1:0]           to_cnt_reg, to_cnt_next, to_cnt_inc;
  logic                    ack_to_reg, ack_to_next;
  logic                    ovf_reg;
  logic [DATA_WIDTH-1:0]   cur_byte;

  assign rf_entry   = {TAG_RF, {DATA_WIDTH{1'b0}}, RdData};
  assign alu_entry  = {TAG_ALU, ALU_OUT};
  assign free_slots = CW'(FIFO_DEPTH) - fifo_count;

  // Slot decisions use the pre-edge occupancy, so a pop this cycle never makes room.
  always_comb begin
    push0      = 1'b0;
    push1      = 1'b0;
    push0_data = rf_entry;
    push1_data = alu_entry;
    drop       = 1'b0;
    if (RdData_Valid && OUT_VALID) begin
      if (free_slots >= CW'(2)) begin
        push0 = 1'b1;
        push1 = 1'b1;
      end else if (free_slots == CW'(1)) begin
        push0 = 1'b1;
        drop  = 1'b1;
      end else begin
        drop  = 1'b1;
      end
    end else if (RdData_Valid) begin
      if (!fifo_full) push0 = 1'b1;
      else            drop  = 1'b1;
    end else if (OUT_VALID) begin
      push0_data = alu_entry;
      if (!fifo_full) push0 = 1'b1;
      else            drop  = 1'b1;
    end
  end

  sync_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push0      (push0),
    .push0_data (push0_data),
    .push1      (push1),
    .push1_data (push1_data),
    .pop        (fifo_pop),
    .head_data  (fifo_head),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (fifo_count)
  );

  // ALU frames go out low byte first.
  assign cur_byte   = byte_idx_reg ? frame_reg[2*DATA_WIDTH-1:DATA_WIDTH]
                                   : frame_reg[DATA_WIDTH-1:0];
  assign to_cnt_inc = to_cnt_reg + TW'(1);

  always_comb begin
    state_next    = state_reg;
    frame_next    = frame_reg;
    byte_idx_next = byte_idx_reg;
    tx_data_next  = tx_data_reg;
    tx_vld_next   = tx_vld_reg;
    to_cnt_next   = to_cnt_reg;
    ack_to_next   = 1'b0;
    fifo_pop      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop      = 1'b1;
          frame_next    = fifo_head;
          byte_idx_next = 1'b0;
          state_next    = ST_WAIT_FREE;
        end
      end
      ST_WAIT_FREE: begin
        if (!Busy) begin
          tx_data_next = cur_byte;
          tx_vld_next  = 1'b1;
          to_cnt_next  = '0;
          state_next   = ST_SEND;
        end
      end
      ST_SEND: begin
        if (Busy) begin
          tx_vld_next = 1'b0;
          state_next  = ST_WAIT_DONE;
        end else begin
          to_cnt_next = to_cnt_inc;
          // Ack never came: drop whatever is left of this frame.
          if (to_cnt_inc == TW'(ACK_TIMEOUT)) begin
            tx_vld_next = 1'b0;
            ack_to_next = 1'b1;
            state_next  = ST_IDLE;
          end
        end
      end
      ST_WAIT_DONE: begin
        if (!Busy) begin
          if (frame_reg[EW-1] == TAG_ALU && !byte_idx_reg) begin
            byte_idx_next = 1'b1;
            state_next    = ST_WAIT_FREE;
          end else begin
            state_next    = ST_IDLE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      frame_reg    <= '0;
      byte_idx_reg <= 1'b0;
      tx_data_reg  <= '0;
      tx_vld_reg   <= 1'b0;
      to_cnt_reg   <= '0;
      ack_to_reg   <= 1'b0;
      ovf_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      frame_reg    <= frame_next;
      byte_idx_reg <= byte_idx_next;
      tx_data_reg  <= tx_data_next;
      tx_vld_reg   <= tx_vld_next;
      to_cnt_reg   <= to_cnt_next;
      ack_to_reg   <= ack_to_next;
      ovf_reg      <= drop;
    end
  end

  assign TX_P_DATA   = tx_data_reg;
  assign TX_D_VLD    = tx_vld_reg;
  assign Fifo_Full   = fifo_full;
  assign Overflow    = ovf_reg;
  assign Ack_Timeout = ack_to_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a byte-stream scoreboard plus a UART
// Busy responder, with literal expectations for latency, ordering and timeouts.
module tb_uart_tx_arbiter;

  localparam int ACKT = 255;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  RdData = '0;
  logic        RdData_Valid = 1'b0;
  logic [15:0] ALU_OUT = '0;
  logic        OUT_VALID = 1'b0;
  logic        Busy = 1'b0;
  logic [7:0]  TX_P_DATA;
  logic        TX_D_VLD;
  logic        Fifo_Full;
  logic        Overflow;
  logic        Ack_Timeout;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .DATA_WIDTH  (8),
    .FIFO_DEPTH  (4),
    .ACK_TIMEOUT (ACKT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .RdData       (RdData),
    .RdData_Valid (RdData_Valid),
    .ALU_OUT      (ALU_OUT),
    .OUT_VALID    (OUT_VALID),
    .Busy         (Busy),
    .TX_P_DATA    (TX_P_DATA),
    .TX_D_VLD     (TX_D_VLD),
    .Fifo_Full    (Fifo_Full),
    .Overflow     (Overflow),
    .Ack_Timeout  (Ack_Timeout)
  );

  typedef struct { logic [7:0] b; bit last; } exp_byte_t;

  int          n_chk = 0;
  int          n_pass = 0;
  int          cyc = 0;
  exp_byte_t   exp_q[$];
  logic [7:0]  sent_log[$];
  bit          drop_at[int];
  int          busy_mode = 0;   // 0: UART responder, 1: held high, 2: held low
  int          busy_left = 0;

  bit          prev_vld = 1'b0;
  bit          prev_busy = 1'b0;
  logic [7:0]  held = '0;
  int          run = 0;
  bit          to_pend = 1'b0;
  bit          cur_last = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
  endtask

  // UART model: Busy rises just after TX_D_VLD appears and stays high 10 cycles.
  always @(posedge clk) begin
    #2;
    case (busy_mode)
      1: Busy = 1'b1;
      2: begin Busy = 1'b0; busy_left = 0; end
      default: begin
        if (busy_left > 0) begin
          Busy = 1'b1;
          busy_left--;
        end else if (TX_D_VLD && !Busy) begin
          Busy = 1'b1;
          busy_left = 9;
        end else begin
          Busy = 1'b0;
        end
      end
    endcase
  end

  // Per-cycle compare against the frame/byte model.
  initial begin : compare
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_vld = 1'b0; prev_busy = Busy; run = 0; to_pend = 1'b0; cur_last = 1'b1;
        continue;
      end
      chk("overflow", Overflow, 32'(drop_at.exists(cyc - 1)));
      chk("ack_timeout", Ack_Timeout, to_pend);
      if (to_pend) begin
        chk("vld_low_after_timeout", TX_D_VLD, 0);
        while (!cur_last && exp_q.size() != 0) begin
          cur_last = exp_q[0].last;
          void'(exp_q.pop_front());
        end
        cur_last = 1'b1;
        run = 0;
      end
      to_pend = 1'b0;
      if (TX_D_VLD && !prev_vld) begin
        sent_log.push_back(TX_P_DATA);
        $display("byte 0x%02h sent at cycle %0d", TX_P_DATA, cyc);
        chk("busy_low_before_send", prev_busy, 0);
        chk("byte_available", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          chk("tx_byte", TX_P_DATA, exp_q[0].b);
          cur_last = exp_q[0].last;
          void'(exp_q.pop_front());
        end
        held = TX_P_DATA;
        run = 0;
      end else if (TX_D_VLD) begin
        chk("tx_stable", TX_P_DATA, held);
      end
      if (TX_D_VLD && !Busy) begin
        run++;
        if (run == ACKT) to_pend = 1'b1;
      end
      prev_vld  = TX_D_VLD;
      prev_busy = Busy;
    end
  end

  // Call at a negedge; drives the valids for the next edge and records what must be accepted.
  task automatic drive(input bit rv, input logic [7:0] rd, input bit av, input logic [15:0] ad,
                       input bit r_acc, input bit a_acc);
    RdData = rd; RdData_Valid = rv; ALU_OUT = ad; OUT_VALID = av;
    if (rv && r_acc) exp_q.push_back('{rd, 1'b1});
    if (av && a_acc) begin
      exp_q.push_back('{ad[7:0], 1'b0});
      exp_q.push_back('{ad[15:8], 1'b1});
    end
    if ((rv && !r_acc) || (av && !a_acc)) drop_at[cyc] = 1'b1;
    @(negedge clk);
  endtask

  task automatic idle_in();
    RdData_Valid = 1'b0;
    OUT_VALID = 1'b0;
  endtask

  task automatic wait_quiet();
    int n = 0;
    while ((exp_q.size() != 0 || TX_D_VLD || Busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_in_time", 32'(n < 3000), 1);
    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
  endtask

  task automatic wait_vld_rise(output int at_cyc);
    int n = 0;
    while (!TX_D_VLD && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("vld_rise_in_time", 32'(n < 500), 1);
    at_cyc = cyc;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_tx_d_vld"}, TX_D_VLD, 0);
    chk({tag, "_tx_p_data"}, TX_P_DATA, 0);
    chk({tag, "_fifo_full"}, Fifo_Full, 0);
    chk({tag, "_overflow"}, Overflow, 0);
    chk({tag, "_ack_timeout"}, Ack_Timeout, 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d, required completion", cyc);
    $fatal(1, "simulation time limit reached");
  end

  initial begin : main
    int t_rise, t_ack, n;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    // Single RF byte: TX_D_VLD appears after the third edge.
    sent_log.delete();
    drive(1, 8'hA5, 0, 16'h0, 1, 0);
    idle_in();
    chk("lat_after_e0", TX_D_VLD, 0);
    @(negedge clk);
    chk("lat_after_e1", TX_D_VLD, 0);
    @(negedge clk);
    chk("lat_after_e2", TX_D_VLD, 1);
    chk("lat_data", TX_P_DATA, 8'hA5);
    wait_quiet();
    chk("rf_count", sent_log.size(), 1);

    // ALU frame: low byte then high byte.
    sent_log.delete();
    drive(0, 8'h00, 1, 16'h1234, 0, 1);
    idle_in();
    wait_quiet();
    chk("alu_count", sent_log.size(), 2);
    chk("alu_b0", sent_log[0], 8'h34);
    chk("alu_b1", sent_log[1], 8'h12);

    // Simultaneous RF and ALU on an empty queue.
    sent_log.delete();
    drive(1, 8'h11, 1, 16'hBEEF, 1, 1);
    idle_in();
    wait_quiet();
    chk("dual_count", sent_log.size(), 3);
    chk("dual_b0", sent_log[0], 8'h11);
    chk("dual_b1", sent_log[1], 8'hEF);
    chk("dual_b2", sent_log[2], 8'hBE);

    // Fill while Busy is stuck high; the first frame is already held by the sender.
    sent_log.delete();
    busy_mode = 1;
    @(negedge clk);
    drive(1, 8'h50, 0, 16'h0, 1, 0);
    idle_in();
    repeat (4) @(negedge clk);
    drive(1, 8'h01, 0, 16'h0, 1, 0);
    drive(1, 8'h02, 0, 16'h0, 1, 0);
    drive(1, 8'h03, 0, 16'h0, 1, 0);
    chk("full_after_3", Fifo_Full, 0);
    drive(1, 8'h04, 0, 16'h0, 1, 0);
    chk("full_after_4", Fifo_Full, 1);
    drive(1, 8'h05, 0, 16'h0, 0, 0);
    idle_in();
    chk("full_after_5", Fifo_Full, 1);
    busy_mode = 0;
    wait_quiet();
    chk("fill_count", sent_log.size(), 5);
    chk("fill_last", sent_log[4], 8'h04);
    chk("full_cleared", Fifo_Full, 0);

    // Dual push with one slot free, then with none.
    sent_log.delete();
    busy_mode = 1;
    @(negedge clk);
    drive(1, 8'h60, 0, 16'h0, 1, 0);
    idle_in();
    repeat (4) @(negedge clk);
    drive(1, 8'h61, 0, 16'h0, 1, 0);
    drive(1, 8'h62, 0, 16'h0, 1, 0);
    drive(1, 8'h63, 0, 16'h0, 1, 0);
    drive(1, 8'h64, 1, 16'h7788, 1, 0);
    chk("one_slot_full", Fifo_Full, 1);
    drive(1, 8'h65, 1, 16'h9999, 0, 0);
    idle_in();
    busy_mode = 0;
    wait_quiet();
    chk("slot_count", sent_log.size(), 5);
    chk("slot_last", sent_log[4], 8'h64);

    // Lost ack: ALU byte 0 times out, byte 1 is discarded, next frame goes out.
    sent_log.delete();
    busy_mode = 2;
    @(negedge clk);
    drive(0, 8'h00, 1, 16'hCAFE, 0, 1);
    drive(1, 8'h77, 0, 16'h0, 1, 0);
    idle_in();
    wait_vld_rise(t_rise);
    n = 0;
    while (!Ack_Timeout && n < 400) begin
      @(negedge clk);
      n++;
    end
    t_ack = cyc;
    chk("ack_seen", Ack_Timeout, 1);
    chk("ack_cycles", t_ack - t_rise, ACKT);
    busy_mode = 0;
    wait_quiet();
    chk("to_count", sent_log.size(), 2);
    chk("to_b0", sent_log[0], 8'hFE);
    chk("to_b1", sent_log[1], 8'h77);

    // Reset while ALU byte 0 is in SEND with another frame queued.
    sent_log.delete();
    drive(0, 8'h00, 1, 16'h5A3C, 0, 1);
    drive(1, 8'h99, 0, 16'h0, 1, 0);
    idle_in();
    wait_vld_rise(t_rise);
    #1;
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk_all_zero("midreset");
    reset = 1'b0;
    repeat (40) @(negedge clk);
    chk("reset_count", sent_log.size(), 1);
    chk("reset_b0", sent_log[0], 8'h3C);
    chk("reset_idle_vld", TX_D_VLD, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
